// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: formats loads/stores onto a split-transaction
// SRAM-like bus (req/addr_ok then data_ok), stalls the pipeline while busy, flags misalignment.
module mem_access_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        memenM,
    input  logic        MemWriteM,
    input  logic [7:0]  ALUControlM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    input  logic        excM,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        stallM,
    output logic [31:0] readdataM,
    output logic        adelM_o,
    output logic        adesM_o,
    output logic [31:0] badvaddrM
);

    localparam logic [7:0] OP_LB  = 8'hE0;
    localparam logic [7:0] OP_LBU = 8'hE1;
    localparam logic [7:0] OP_LH  = 8'hE2;
    localparam logic [7:0] OP_LHU = 8'hE3;
    localparam logic [7:0] OP_LW  = 8'hE4;
    localparam logic [7:0] OP_SB  = 8'hE5;
    localparam logic [7:0] OP_SH  = 8'hE6;
    localparam logic [7:0] OP_SW  = 8'hE7;

    // Handshake: a request is accepted in the cycle data_req & data_addr_ok are both high;
    // the response completes in the later cycle data_data_ok is high while in S_WAIT.
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_rbuf;
    logic [1:0]  r_off;
    logic [7:0]  r_op;

    logic        w_is_byte;
    logic        w_is_half;
    logic        w_is_word;
    logic        w_misaligned;
    logic        w_start;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_is_byte = (ALUControlM == OP_LB) || (ALUControlM == OP_LBU) || (ALUControlM == OP_SB);
    assign w_is_half = (ALUControlM == OP_LH) || (ALUControlM == OP_LHU) || (ALUControlM == OP_SH);
    assign w_is_word = (ALUControlM == OP_LW) || (ALUControlM == OP_SW);

    assign w_misaligned = (w_is_half & aluoutM[0]) | (w_is_word & (aluoutM[1:0] != 2'b00));
    // Gated by reset so no request or stall escapes while reset is asserted.
    assign w_start      = reset & memenM & ~w_misaligned & ~excM;

    assign adelM_o   = memenM & ~MemWriteM & w_misaligned;
    assign adesM_o   = memenM & MemWriteM & w_misaligned;
    assign badvaddrM = aluoutM;

    assign data_wr   = MemWriteM;
    assign data_addr = aluoutM;

    always_comb begin
        data_size  = 2'd2;
        data_wdata = writedataM;
        if (w_is_byte) begin
            data_size  = 2'd0;
            data_wdata = {4{writedataM[7:0]}};
        end else if (w_is_half) begin
            data_size  = 2'd1;
            data_wdata = {2{writedataM[15:0]}};
        end
    end

    always_comb begin
        w_next   = r_state;
        data_req = 1'b0;
        stallM   = 1'b0;
        case (r_state)
            S_IDLE: begin
                data_req = w_start;
                stallM   = w_start;
                if (w_start) w_next = data_addr_ok ? S_WAIT : S_REQ;
            end
            S_REQ: begin
                data_req = 1'b1;
                stallM   = 1'b1;
                if (data_addr_ok) w_next = S_WAIT;
            end
            S_WAIT: begin
                stallM = 1'b1;
                if (data_data_ok) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_rbuf  <= 32'h0;
            r_off   <= 2'b00;
            r_op    <= 8'h00;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_start) begin
                r_off <= aluoutM[1:0];
                r_op  <= ALUControlM;
            end
            if (r_state == S_WAIT && data_data_ok) r_rbuf <= data_rdata;
        end
    end

    always_comb begin
        case (r_off)
            2'd0:    w_byte = r_rbuf[7:0];
            2'd1:    w_byte = r_rbuf[15:8];
            2'd2:    w_byte = r_rbuf[23:16];
            default: w_byte = r_rbuf[31:24];
        endcase
        w_half = r_off[1] ? r_rbuf[31:16] : r_rbuf[15:0];
    end

    always_comb begin
        readdataM = 32'h0;
        if (r_state == S_DONE) begin
            case (r_op)
                OP_LB:   readdataM = {{24{w_byte[7]}}, w_byte};
                OP_LBU:  readdataM = {24'h0, w_byte};
                OP_LH:   readdataM = {{16{w_half[15]}}, w_half};
                OP_LHU:  readdataM = {16'h0, w_half};
                OP_LW:   readdataM = r_rbuf;
                default: readdataM = 32'h0;
            endcase
        end
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-stage data-access controller that consumes the EX/MEM register outputs (memenM, MemWriteM, ALUControlM, aluoutM, writedataM) and drives an SRAM-like split-transaction data bus (request/addr_ok, then data_ok). It is the bus initiator and the load/store formatter. It stalls the pipeline while a transaction is outstanding, returns sign- or zero-extended load data, and flags misaligned accesses as address-error exceptions.

## Interface
Parameters: none.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset: 0 = reset asserted.
- memenM  in  1  M-stage instruction is a load or store.
- MemWriteM  in  1  1 = store, 0 = load (valid when memenM=1).
- ALUControlM  in  8  access op: 8'hE0 LB, E1 LBU, E2 LH, E3 LHU, E4 LW, E5 SB, E6 SH, E7 SW.
- aluoutM  in  32  effective address.
- writedataM  in  32  store source register value.
- excM  in  1  M-stage instruction already carries an exception; suppresses the access.
- data_req  out  1  bus request.
- data_wr  out  1  1 = write.
- data_size  out  2  0 byte, 1 half, 2 word.
- data_addr  out  32  byte address (= aluoutM).
- data_wdata  out  32  lane-replicated store data.
- data_addr_ok  in  1  request accepted this cycle.
- data_data_ok  in  1  read data valid / write completed this cycle.
- data_rdata  in  32  read data.
- stallM  out  1  hold the M stage and all earlier stages.
- readdataM  out  32  extended load result, valid in DONE.
- adelM_o  out  1  load address error.
- adesM_o  out  1  store address error.
- badvaddrM  out  32  faulting address (= aluoutM).

## Operation
- misaligned: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0. Byte ops never misalign.
- adelM_o = memenM & ~MemWriteM & misaligned. adesM_o = memenM & MemWriteM & misaligned. Both outputs are combinational.
- start = memenM & ~misaligned & ~excM. It is sampled only in IDLE.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE: data_req = start. If start and addr_ok → WAIT. If start and ~addr_ok → REQ. Otherwise stay in IDLE.
  - REQ: data_req = 1 and the bus fields are held stable. addr_ok → WAIT.
  - WAIT: data_req = 0. data_ok → latch data_rdata into rbuf, then → DONE.
  - DONE: → IDLE unconditionally.
- stallM = (IDLE & start) | REQ | WAIT. stallM = 0 in DONE, so the pipeline advances at the end of the DONE cycle.
- At the request, addr[1:0] and the op are latched for extraction in DONE.
- Store data replication:
  - SB: {4{wd[7:0]}}
  - SH: {2{wd[15:0]}}
  - SW: wd
- Load extraction from rbuf:
  - Byte lane = rbuf[8*a+7:8*a].
  - Half lane = rbuf[16*a[1]+15:16*a[1]].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Stores: rbuf is ignored; readdataM = 0 in DONE.
- Outside DONE, readdataM = 0.
- Once a request has been issued it always completes. excM and a rising flush upstream do not cancel REQ or WAIT.
- data_ok is ignored outside WAIT. The bus guarantees data_ok no earlier than the cycle after addr_ok.

## Timing
- Reset values:
  - state = IDLE, rbuf = 0, latched addr/op = 0.
  - data_req = 0, stallM = 0, readdataM = 0.
  - adelM_o, adesM_o and badvaddrM follow their inputs.
- Reset asserted mid-transaction returns the FSM to IDLE immediately; the outstanding bus transaction is abandoned.
- Minimum access is 3 cycles: IDLE(req, addr_ok) → WAIT(data_ok) → DONE. stallM is high for 2 of these cycles.
- Each cycle without addr_ok adds one cycle in REQ. Each cycle without data_ok adds one cycle in WAIT.
- Back-to-back accesses: after DONE there is one IDLE cycle, in which the next instruction's start is sampled. There is no request in DONE.
- A misaligned access or excM=1 produces no request and no stall; the exception flags are visible in the same cycle.

## Test plan
- LW at 0x100, addr_ok immediately, data_ok 1 cycle later with rdata 0x8899AABB → stallM high for 2 cycles; DONE readdataM = 0x8899AABB; data_size = 2.
- LB at 0x103 with rdata 0x80FFFFFF → readdataM = 0xFFFFFF80. LBU at the same address → 0x00000080.
- SH at 0x202, wd = 0x1234ABCD, addr_ok delayed 3 cycles → data_req held for 4 cycles; data_wdata = 0xABCDABCD; data_wr = 1; data_size = 1; stallM releases in DONE.
- LW at 0x101 → adelM_o = 1, badvaddrM = 0x101, data_req = 0, stallM = 0. SW at 0x102 → adesM_o = 1.
- memenM = 1 with excM = 1 → no request and no stall. Then raise excM during WAIT of a valid load → the load still completes normally.
- Drive reset low during WAIT → stallM = 0 and data_req = 0 immediately. After release, a new LHU at 0x2 with rdata 0xF00D0000 → readdataM = 0x0000F00D.
